// File: rtl/morse_letter_buffer_if.sv
// Done/ack character handshake between the letter-forming stage (master)
// and the message buffer (slave).
interface morse_letter_buffer_if;
   localparam int unsigned CHAR_W = 5;

   logic [CHAR_W-1:0] char_in;
   logic              char_done;
   logic              char_ack;

   modport master (output char_in, output char_done, input char_ack);
   modport slave  (input char_in, input char_done, output char_ack);
endinterface

// File: rtl/morse_letter_buffer.sv
// Circular message buffer for finished Morse characters, with a 4-character
// scrollable display window (newest on the right), backspace and clear.
module morse_letter_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   morse_letter_buffer_if.slave ltr,
   input  logic                 clear,
   input  logic                 bksp,
   input  logic                 scroll_up,
   input  logic                 scroll_dn,
   output logic [4:0]           disp0,
   output logic [4:0]           disp1,
   output logic [4:0]           disp2,
   output logic [4:0]           disp3,
   output logic [PTR_W:0]       count,
   output logic                 full,
   output logic                 err
);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CHAR_W = 5;
   localparam int unsigned WIN    = 4;
   localparam logic [CHAR_W-1:0] BLANK     = 5'd31;
   localparam logic [CHAR_W-1:0] FIRST_BAD = 5'd26;

   typedef enum logic {IDLE, ACK} state_t;

   state_t            state;
   logic [CHAR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  offset;

   logic              capture_c;
   logic              valid_c;
   logic [CNT_W-1:0]  max_off_c;
   logic [CNT_W-1:0]  k_c    [WIN];
   logic [CHAR_W-1:0] disp_c [WIN];

   // A capture is deferred while clear or bksp owns the cycle.
   assign capture_c = (state == IDLE) && ltr.char_done && !clear && !bksp;
   assign valid_c   = ltr.char_in < FIRST_BAD;
   assign max_off_c = (count > CNT_W'(WIN)) ? count - CNT_W'(WIN) : '0;

   // Window slot i shows the entry (offset + i) positions back from the newest.
   always_comb begin
      for (int i = 0; i < WIN; i++) begin
         k_c[i]    = CNT_W'(offset) + CNT_W'(i);
         disp_c[i] = BLANK;
         if (k_c[i] < count) begin
            disp_c[i] = mem[wr_ptr - PTR_W'(1) - k_c[i][PTR_W-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && capture_c && valid_c) begin
         mem[wr_ptr] <= ltr.char_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ltr.char_ack <= 1'b0;
         err          <= 1'b0;
         wr_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         offset       <= '0;
         disp0        <= BLANK;
         disp1        <= BLANK;
         disp2        <= BLANK;
         disp3        <= BLANK;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (capture_c) begin
                  state        <= ACK;
                  ltr.char_ack <= 1'b1;
                  err          <= !valid_c;
               end
            end
            ACK: begin
               if (!ltr.char_done) begin
                  state        <= IDLE;
                  ltr.char_ack <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               ltr.char_ack <= 1'b0;
            end
         endcase

         // Buffer update priority: clear > bksp > capture > scroll.
         if (clear) begin
            count  <= '0;
            wr_ptr <= '0;
            offset <= '0;
            full   <= 1'b0;
         end else if (bksp) begin
            if (count != '0) begin
               wr_ptr <= wr_ptr - PTR_W'(1);
               count  <= count - CNT_W'(1);
               full   <= 1'b0;
               offset <= '0;
            end
         end else if (capture_c) begin
            if (valid_c) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               if (count != CNT_W'(DEPTH)) begin
                  count <= count + CNT_W'(1);
               end
               full   <= (count >= CNT_W'(DEPTH - 1));
               offset <= '0;
            end
         end else if (scroll_up && !scroll_dn) begin
            if (CNT_W'(offset) < max_off_c) begin
               offset <= offset + PTR_W'(1);
            end
         end else if (scroll_dn && !scroll_up) begin
            if (offset != '0) begin
               offset <= offset - PTR_W'(1);
            end
         end

         disp0 <= disp_c[0];
         disp1 <= disp_c[1];
         disp2 <= disp_c[2];
         disp3 <= disp_c[3];
      end
   end
endmodule

// File: tb/tb_morse_letter_buffer.sv
// Directed bench for morse_letter_buffer: a queue-based message model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_morse_letter_buffer;
   localparam int DEPTH = 16;
   localparam int PTR_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             bksp = 1'b0;
   logic             scroll_up = 1'b0;
   logic             scroll_dn = 1'b0;
   logic [4:0]       disp0, disp1, disp2, disp3;
   logic [PTR_W:0]   count;
   logic             full;
   logic             err;

   morse_letter_buffer_if ltr ();

   morse_letter_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .ltr       (ltr.slave),
      .clear     (clear),
      .bksp      (bksp),
      .scroll_up (scroll_up),
      .scroll_dn (scroll_dn),
      .disp0     (disp0),
      .disp1     (disp1),
      .disp2     (disp2),
      .disp3     (disp3),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Message model: oldest character at the front of the queue.
   logic [4:0] msg[$];
   int         m_off = 0;
   bit         m_busy = 1'b0;
   bit         m_valid = 1'b0;
   bit         exp_ack = 1'b0;
   bit         exp_err = 1'b0;
   int         exp_disp[4];
   int         mdl_k, mdl_mx;
   bit         mdl_acc;

   always @(posedge clk) begin
      if (reset) begin
         msg.delete();
         m_off   = 0;
         m_busy  = 1'b0;
         exp_ack = 1'b0;
         exp_err = 1'b0;
         for (int i = 0; i < 4; i++) exp_disp[i] = 31;
         m_valid = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            mdl_k = m_off + i;
            exp_disp[i] = (mdl_k < msg.size()) ? int'(msg[msg.size() - 1 - mdl_k]) : 31;
         end
         mdl_acc = !m_busy && ltr.char_done && !clear && !bksp;
         exp_err = mdl_acc && (ltr.char_in > 5'd25);
         if (mdl_acc) m_busy = 1'b1;
         else if (m_busy && !ltr.char_done) m_busy = 1'b0;
         exp_ack = m_busy;
         if (clear) begin
            msg.delete();
            m_off = 0;
         end else if (bksp) begin
            if (msg.size() > 0) begin
               void'(msg.pop_back());
               m_off = 0;
            end
         end else if (mdl_acc) begin
            if (ltr.char_in <= 5'd25) begin
               msg.push_back(ltr.char_in);
               if (msg.size() > DEPTH) void'(msg.pop_front());
               m_off = 0;
            end
         end else begin
            mdl_mx = (msg.size() > 4) ? msg.size() - 4 : 0;
            if (scroll_up && !scroll_dn && m_off < mdl_mx) m_off++;
            else if (scroll_dn && !scroll_up && m_off > 0) m_off--;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("char_ack", int'(ltr.char_ack), int'(exp_ack));
         check("err", int'(err), int'(exp_err));
         check("count", int'(count), msg.size());
         check("full", int'(full), int'(msg.size() == DEPTH));
         check("disp0", int'(disp0), exp_disp[0]);
         check("disp1", int'(disp1), exp_disp[1]);
         check("disp2", int'(disp2), exp_disp[2]);
         check("disp3", int'(disp3), exp_disp[3]);
      end
   end

   task automatic send_char(input int code, input int hold);
      int n;
      @(negedge clk);
      ltr.char_in   = 5'(code);
      ltr.char_done = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ltr.char_ack && n < 8);
      check("ack_rise", int'(ltr.char_ack), 1);
      repeat (hold - 1) @(negedge clk);
      ltr.char_done = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ltr.char_ack && n < 8);
      check("ack_fall", int'(ltr.char_ack), 0);
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic pulse_bksp();
      @(negedge clk); bksp = 1'b1;
      @(negedge clk); bksp = 1'b0;
   endtask

   task automatic pulse_scroll(input bit up);
      @(negedge clk);
      if (up) scroll_up = 1'b1; else scroll_dn = 1'b1;
      @(negedge clk);
      scroll_up = 1'b0;
      scroll_dn = 1'b0;
   endtask

   task automatic check_win(input string tag, input int d3, input int d2, input int d1, input int d0);
      check({tag, "_d3"}, int'(disp3), d3);
      check({tag, "_d2"}, int'(disp2), d2);
      check({tag, "_d1"}, int'(disp1), d1);
      check({tag, "_d0"}, int'(disp0), d0);
   endtask

   initial begin
      ltr.char_in   = 5'd0;
      ltr.char_done = 1'b0;
      repeat (2) @(negedge clk);
      check_win("rst", 31, 31, 31, 31);
      check("rst_count", int'(count), 0);
      reset = 1'b0;

      // H held for three cycles: one stored character.
      send_char(7, 3);
      @(negedge clk);
      check("h_count", int'(count), 1);
      check_win("h", 31, 31, 31, 7);

      // A-F, then scroll to the oldest window and past its limit.
      pulse_clear();
      for (int c = 0; c <= 5; c++) send_char(c, 1);
      @(negedge clk);
      check("af_count", int'(count), 6);
      check_win("af", 2, 3, 4, 5);
      repeat (3) pulse_scroll(1'b1);
      @(negedge clk);
      check_win("af_up", 0, 1, 2, 3);
      send_char(6, 2);
      @(negedge clk);
      check_win("g", 3, 4, 5, 6);

      // Overfill a 16-entry buffer and scroll to the far end.
      pulse_clear();
      for (int c = 0; c <= 16; c++) send_char(c, 1);
      @(negedge clk);
      check("ovf_count", int'(count), 16);
      check("ovf_full", int'(full), 1);
      repeat (13) pulse_scroll(1'b1);
      @(negedge clk);
      check_win("ovf_up", 1, 2, 3, 4);
      pulse_scroll(1'b0);
      @(negedge clk);
      check_win("ovf_dn", 2, 3, 4, 5);

      // Backspace down to empty and beyond.
      pulse_clear();
      send_char(8, 1);
      send_char(9, 1);
      send_char(10, 1);
      pulse_bksp();
      @(negedge clk);
      check("bk_count", int'(count), 2);
      check_win("bk", 31, 31, 8, 9);
      repeat (3) pulse_bksp();
      @(negedge clk);
      check("bk0_count", int'(count), 0);
      check_win("bk0", 31, 31, 31, 31);

      // Invalid code is acknowledged but not stored.
      send_char(30, 2);
      @(negedge clk);
      check("inv_count", int'(count), 0);

      // clear coinciding with a new done: clear first, character next edge.
      send_char(1, 1);
      send_char(2, 1);
      @(negedge clk);
      clear         = 1'b1;
      ltr.char_in   = 5'd4;
      ltr.char_done = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_defer_ack", int'(ltr.char_ack), 0);
      @(negedge clk);
      check("clr_take_ack", int'(ltr.char_ack), 1);
      ltr.char_done = 1'b0;
      repeat (2) @(negedge clk);
      check("clr_count", int'(count), 1);
      check_win("clr", 31, 31, 31, 4);

      // Reset in the middle of a handshake.
      @(negedge clk);
      ltr.char_in   = 5'd11;
      ltr.char_done = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_rst_ack", int'(ltr.char_ack), 1);
      reset         = 1'b1;
      ltr.char_done = 1'b0;
      @(negedge clk);
      check("mid_rst_ack", int'(ltr.char_ack), 0);
      check("mid_rst_count", int'(count), 0);
      check_win("mid_rst", 31, 31, 31, 31);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/morse_letter_buffer.md
Name: morse_letter_buffer

Overview:
- Downstream consumer of the letter-forming stage, which presents a 5-bit character with a level `done` and waits for `ack`.
- Accepts each finished character through that done/ack handshake and stores it in a circular message buffer.
- Drives a 4-character display window (newest on the right) with scroll, backspace and clear controls.
- Its outputs feed the seven-segment/LCD driver.

Parameters:
- DEPTH, 16, number of stored characters; power of two, >= 4.
- PTR_W, 4, pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- char_in  input  5  character code from the letter stage: 0-25 = A-Z; 26-31 invalid
- char_done  input  1  level; high while char_in is valid; held until acknowledged
- char_ack  output  1  acknowledge to the letter stage
- clear  input  1  one-cycle pulse; empties the buffer
- bksp  input  1  one-cycle pulse; deletes the newest character
- scroll_up  input  1  one-cycle pulse; view one character older
- scroll_dn  input  1  one-cycle pulse; view one character newer
- disp0  output  5  rightmost display character; 5'd31 = blank
- disp1  output  5  display character, one left of disp0
- disp2  output  5  display character, two left of disp0
- disp3  output  5  leftmost display character
- count  output  PTR_W+1  number of stored characters, 0..DEPTH
- full  output  1  high when count == DEPTH
- err  output  1  one-cycle pulse when an invalid code is acknowledged

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state = IDLE; char_ack = 0; err = 0
  - wr_ptr = 0; count = 0; full = 0; view offset = 0
  - disp0..disp3 = 5'd31
  - Buffer contents are don't-care.
- Reset mid-handshake: returns to IDLE with char_ack low. A char_done still held high afterwards is treated as a new character.
- Handshake FSM, IDLE:
  - If char_done = 1 and clear = 0 and bksp = 0: capture char_in, go to ACK.
  - If clear or bksp is high in the same cycle, capture is deferred one cycle; char_done is still high then and is taken.
- Handshake FSM, ACK:
  - char_ack = 1 (registered output, equal to state == ACK).
  - Stay in ACK while char_done = 1; go to IDLE when char_done = 0.
  - Exactly one character is stored per done assertion, however long done is held.
- Capture of a valid code (0-25):
  - buf[wr_ptr] <= char_in; wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
  - count <= min(count + 1, DEPTH).
  - Buffer full: the oldest entry is overwritten; count stays DEPTH; full stays 1.
  - View offset resets to 0.
- Capture of an invalid code (26-31): acknowledged normally, not stored; err = 1 for the cycle char_ack first rises.
- Latency: char_done sampled high in IDLE at edge E. char_ack is high from E. disp0 shows the new character from edge E+1.
- clear: count <= 0; wr_ptr <= 0; offset <= 0; full <= 0. Highest priority.
- bksp:
  - If count > 0: wr_ptr <= wr_ptr - 1 (wrapping); count <= count - 1; offset <= 0.
  - If count = 0: no effect.
- Priority in one cycle: clear > bksp > character capture > scroll. Scroll is ignored in any cycle where clear, bksp or a capture occurs.
- Scroll limits, with max_off = (count > 4) ? count - 4 : 0:
  - scroll_up: offset <= offset + 1 if offset < max_off, else hold.
  - scroll_dn: offset <= offset - 1 if offset > 0, else hold.
  - scroll_up and scroll_dn together: hold.
- Display (registered, updated every cycle from the post-update state of the previous edge):
  - k = offset + i for disp_i, i = 0..3.
  - disp_i = buf[(wr_ptr - 1 - k) mod DEPTH] if k < count, else 5'd31.
- full = (count == DEPTH), registered together with count.

Test Plan:
- Reset, then char_in = 7 (H) with char_done held 3 cycles before dropping → char_ack high from the capture edge until one cycle after done falls; count = 1; disp0 = 7; disp1..disp3 = 31; exactly one write.
- Send codes 0,1,2,3,4,5 (A-F) → count = 6; disp3..disp0 = 2,3,4,5. Then scroll_up ×3 → offset saturates at 2; disp3..disp0 = 0,1,2,3. Then a new char 6 → offset = 0; disp0 = 6.
- Send 17 characters into DEPTH = 16 (codes 0..16) → count = 16; full = 1; oldest (0) overwritten; scrolling to max_off = 12 shows disp3 = 1.
- bksp with count = 3 (codes 8,9,10) → count = 2; disp0 = 9; disp2 = 31. bksp ×3 more → count = 0, holds at 0; all disp = 31.
- char_done high with char_in = 30 → char_ack handshake completes; err pulses once; count unchanged.
- clear asserted in the same cycle char_done rises with char_in = 4 → buffer emptied that edge; char 4 captured next edge; count = 1; disp0 = 4. Assert reset while in ACK → char_ack = 0, count = 0, all disp = 31 next cycle.
